quad_decoder: RTL

Decodes a two-channel mechanical quadrature rotary encoder into single-cycle clockwise/counter-clockwise detent pulses and a wrapping position count. It is the producer side of the up/down counting path: it turns raw encoder pins into the direction events that up/down counters consume. The block synchronizes and glitch-filters the asynchronous pins, tracks the Gray-code phase, and reports illegal transitions.

---
 rtl/quad_decoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// Quadrature rotary-encoder decoder: synchronize, glitch-filter, track Gray phase,
// emit cw/ccw detent pulses, a wrapping position count and illegal-transition errors.
module quad_decoder #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int COUNT_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               a,
   input  logic               b,
   output logic               cw,
   output logic               ccw,
   output logic [COUNT_W-1:0] position,
   output logic               err
);

   localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

   typedef enum logic [1:0] {P00 = 2'b00, P01 = 2'b01, P11 = 2'b11, P10 = 2'b10} phase_t;

   logic [SYNC_STAGES-1:0] a_sync, b_sync;
   logic [1:0]             s, cand, f;
   logic [CNT_W-1:0]       stab_cnt, cnt_nxt;
   phase_t                 state;
   logic [1:0]             st;
   logic signed [3:0]      sub, sub_upd;
   logic                   cw_step, ccw_step, illegal;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sync <= '0;
         b_sync <= '0;
      end else begin
         a_sync <= {a_sync[SYNC_STAGES-2:0], a};
         b_sync <= {b_sync[SYNC_STAGES-2:0], b};
      end
   end

   assign s = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

   always_comb begin
      cnt_nxt = stab_cnt;
      if (s != cand)
         cnt_nxt = CNT_W'(1);
      else if (stab_cnt < CNT_W'(FILTER_CYCLES))
         cnt_nxt = stab_cnt + CNT_W'(1);
   end

   // f takes the candidate on the same edge the stability count reaches its target
   always_ff @(posedge clk) begin
      if (reset) begin
         cand     <= 2'b00;
         stab_cnt <= '0;
         f        <= 2'b00;
      end else begin
         cand     <= s;
         stab_cnt <= cnt_nxt;
         if (cnt_nxt == CNT_W'(FILTER_CYCLES) && s != f)
            f <= s;
      end
   end

   // Clockwise successor of phase {x,y} is {y,~x}
   assign st       = state;
   assign cw_step  = (f == {st[0], ~st[1]});
   assign ccw_step = (st == {f[0], ~f[1]});
   assign illegal  = ((f ^ st) == 2'b11);

   always_comb begin
      sub_upd = sub;
      if (cw_step)
         sub_upd = (sub == 4'sd4) ? sub : sub + 4'sd1;
      else if (ccw_step)
         sub_upd = (sub == -4'sd4) ? sub : sub - 4'sd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= P00;
         sub      <= '0;
         position <= '0;
         cw       <= 1'b0;
         ccw      <= 1'b0;
         err      <= 1'b0;
      end else begin
         cw  <= 1'b0;
         ccw <= 1'b0;
         err <= 1'b0;
         if (illegal) begin
            err   <= 1'b1;
            sub   <= '0;
            state <= phase_t'(f);
         end else if (cw_step || ccw_step) begin
            state <= phase_t'(f);
            if (phase_t'(f) == P00) begin
               sub <= '0;
               if (sub_upd == 4'sd4) begin
                  cw       <= 1'b1;
                  position <= position + COUNT_W'(1);
               end else if (sub_upd == -4'sd4) begin
                  ccw      <= 1'b1;
                  position <= position - COUNT_W'(1);
               end
            end else begin
               sub <= sub_upd;
            end
         end
      end
   end

endmodule
